// File: rtl/line_mem_responder_if.sv
// Line-granular memory request/response bundle between an L1 cache and
// its backing line memory.
interface line_mem_responder_if #(
  parameter int LINE_BITS = 512
);
  logic [31:0]          mem_address;
  logic [LINE_BITS-1:0] mem_write_data;
  logic                 mem_write_enable;
  logic                 mem_read_enable;
  logic [LINE_BITS-1:0] mem_read_data;
  logic                 mem_ready;
  logic                 mem_err;
  logic                 busy;

  modport master (
    output mem_address,
    output mem_write_data,
    output mem_write_enable,
    output mem_read_enable,
    input  mem_read_data,
    input  mem_ready,
    input  mem_err,
    input  busy
  );

  modport slave (
    input  mem_address,
    input  mem_write_data,
    input  mem_write_enable,
    input  mem_read_enable,
    output mem_read_data,
    output mem_ready,
    output mem_err,
    output busy
  );
endinterface

// File: rtl/line_mem_responder.sv
// Memory-side responder for whole-line fills and write-through stores.
// Internal line array with a programmable request-to-ready latency.
module line_mem_responder #(
  parameter int          LINE_BITS = 512,
  parameter int          DEPTH     = 64,
  parameter int          LATENCY   = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input logic            clk,
  input logic            reset,
  line_mem_responder_if.slave bus
);

  localparam int LINE_BYTES = LINE_BITS / 8;
  localparam int OFFW       = $clog2(LINE_BYTES);
  localparam int AW         = $clog2(DEPTH);
  localparam int CW         = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    RECOVER
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [31:0]          addr_q, addr_d;
  logic [LINE_BITS-1:0] wdata_q, wdata_d;
  logic                 wr_q, wr_d;
  logic                 conf_q, conf_d;
  logic                 ready_q, ready_d;
  logic                 err_q, err_d;
  logic [LINE_BITS-1:0] rdata_q, rdata_d;
  logic                 busy_q, busy_d;

  logic [LINE_BITS-1:0] mem [DEPTH];
  logic [31:0]          off;
  logic [31:0]          idx;
  logic                 in_range;
  logic                 mem_we;
  logic                 req;

  assign req = bus.mem_read_enable | bus.mem_write_enable;

  // Next-state, request latch and response generation; the response is
  // decided from the latched request at the edge that enters RESP.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_d     = wr_q;
    conf_d   = conf_q;
    ready_d  = 1'b0;
    err_d    = 1'b0;
    rdata_d  = '0;
    mem_we   = 1'b0;
    off      = '0;
    idx      = '0;
    in_range = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = bus.mem_address;
          wdata_d = bus.mem_write_data;
          wr_d    = bus.mem_write_enable;
          conf_d  = bus.mem_read_enable & bus.mem_write_enable;
          cnt_d   = CW'(LATENCY - 1);
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = RESP;
      end
      RESP: begin
        state_d = RECOVER;
      end
      RECOVER: begin
        if (!req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == RESP && state_q != RESP) begin
      off      = addr_d - BASE_ADDR;
      idx      = off >> OFFW;
      in_range = (addr_d >= BASE_ADDR) && (idx < 32'(DEPTH));
      ready_d  = 1'b1;
      if (wr_d) begin
        mem_we = in_range;
        err_d  = conf_d | ~in_range;
      end else begin
        err_d = ~in_range;
        if (in_range) rdata_d = mem[idx[AW-1:0]];
      end
    end

    busy_d = (state_d != IDLE);
  end

  // Control and output registers; an asserted reset drops any request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      conf_q  <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      conf_q  <= conf_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
    end
  end

  // Line array; contents survive reset, so only the write port is gated.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[idx[AW-1:0]] <= wdata_d;
  end

  assign bus.mem_ready     = ready_q;
  assign bus.mem_err       = err_q;
  assign bus.mem_read_data = rdata_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed plus randomized bench for line_mem_responder.
// Two instances: LATENCY=4 and LATENCY=1, checked against a line model.
module tb_line_mem_responder;

  localparam int LB = 512;

  logic clk = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [LB-1:0] m0 [64];
  logic [LB-1:0] m1 [64];

  line_mem_responder_if #(.LINE_BITS(LB)) if0 ();
  line_mem_responder_if #(.LINE_BITS(LB)) if1 ();

  line_mem_responder #(.LINE_BITS(LB), .DEPTH(64), .LATENCY(4),
                       .BASE_ADDR(32'h0)) dut0 (
    .clk(clk), .reset(rst0), .bus(if0)
  );

  line_mem_responder #(.LINE_BITS(LB), .DEPTH(64), .LATENCY(1),
                       .BASE_ADDR(32'h0)) dut1 (
    .clk(clk), .reset(rst1), .bus(if1)
  );

  always #5 clk = ~clk;

  function automatic logic [LB-1:0] rnd_line();
    logic [LB-1:0] v;
    for (int i = 0; i < LB / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [LB-1:0] got,
                     input logic [LB-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [LB-1:0] d);
    if (sel == 0) begin
      if0.mem_read_enable  = rd;
      if0.mem_write_enable = wr;
      if0.mem_address      = a;
      if0.mem_write_data   = d;
    end else begin
      if1.mem_read_enable  = rd;
      if1.mem_write_enable = wr;
      if1.mem_address      = a;
      if1.mem_write_data   = d;
    end
  endtask

  task automatic sample(input int sel, output logic r, output logic e,
                        output logic b, output logic [LB-1:0] d);
    if (sel == 0) begin
      r = if0.mem_ready; e = if0.mem_err;
      b = if0.busy;      d = if0.mem_read_data;
    end else begin
      r = if1.mem_ready; e = if1.mem_err;
      b = if1.busy;      d = if1.mem_read_data;
    end
  endtask

  // One complete transaction: drive, await the pulse, compare with the
  // line model, optionally hold the enables, then wait for idle.
  task automatic req(input int sel, input bit rd, input bit wr,
                     input logic [31:0] a, input logic [LB-1:0] wd,
                     input int hold, input string tag);
    int lat, cyc, idx, n;
    bit inr, ee, got;
    logic r, e, b;
    logic [LB-1:0] d, ed;
    lat = (sel == 0) ? 4 : 1;
    @(negedge clk);
    drive(sel, rd, wr, a, wd);
    cyc = 0;
    got = 0;
    while (!got && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      sample(sel, r, e, b, d);
      if (r) got = 1;
      else begin
        if (cyc == 1) chk({tag, " busy"}, LB'(b), LB'(1));
        drive(sel, rd, wr, $urandom, rnd_line());
      end
    end
    chk({tag, " latency"}, LB'(cyc), LB'(lat));
    idx = int'(a / 64);
    inr = (a < 32'h1000);
    ee  = !inr || (rd && wr);
    ed  = '0;
    if (wr && inr) begin
      if (sel == 0) m0[idx] = wd;
      else m1[idx] = wd;
    end else if (!wr && inr) begin
      ed = (sel == 0) ? m0[idx] : m1[idx];
    end
    chk({tag, " err"}, LB'(e), LB'(ee));
    chk({tag, " data"}, d, ed);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      sample(sel, r, e, b, d);
      chk({tag, " hold ready"}, LB'(r), LB'(0));
      chk({tag, " hold busy"}, LB'(b), LB'(1));
    end
    drive(sel, 1'b0, 1'b0, 32'h0, '0);
    n = 0;
    do begin
      @(posedge clk); #1;
      sample(sel, r, e, b, d);
      chk({tag, " recover ready"}, LB'(r), LB'(0));
      n++;
    end while (b && n < 6);
    chk({tag, " idle"}, LB'(b), LB'(0));
  endtask

  task automatic chk_zero(input int sel, input string tag);
    logic r, e, b;
    logic [LB-1:0] d;
    sample(sel, r, e, b, d);
    chk({tag, " ready"}, LB'(r), LB'(0));
    chk({tag, " err"}, LB'(e), LB'(0));
    chk({tag, " busy"}, LB'(b), LB'(0));
    chk({tag, " data"}, d, '0);
  endtask

  initial begin
    logic [LB-1:0] a5, dd, old;
    bit seen;
    int op;
    logic [31:0] ra;
    drive(0, 0, 0, 32'h0, '0);
    drive(1, 0, 0, 32'h0, '0);
    for (int i = 0; i < 64; i++) begin
      m0[i] = '0;
      m1[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_zero(0, "reset0");
    chk_zero(1, "reset1");
    @(negedge clk);
    rst0 = 1'b0;
    rst1 = 1'b0;

    for (int i = 0; i < 64; i++) begin
      req(0, 0, 1, 32'(i * 64), rnd_line(), 0, "init0");
      req(1, 0, 1, 32'(i * 64), rnd_line(), 0, "init1");
    end

    a5 = {64{8'hA5}};
    req(0, 0, 1, 32'h40, a5, 0, "wr40");
    req(0, 1, 0, 32'h40, '0, 0, "rd40");

    dd = rnd_line();
    req(0, 0, 1, 32'h7F, dd, 0, "wr7f");
    req(0, 1, 0, 32'h40, '0, 0, "rd40b");
    req(0, 0, 1, 32'hFC0, rnd_line(), 0, "wr63");
    req(0, 1, 0, 32'hFC0, '0, 0, "rd63");

    req(0, 1, 0, 32'h1000, '0, 0, "rd_oor");
    req(0, 0, 1, 32'h1000, rnd_line(), 0, "wr_oor");
    req(0, 1, 0, 32'h40, '0, 0, "rd40c");

    req(0, 1, 0, 32'h40, '0, 5, "hold");

    req(0, 1, 1, 32'h80, rnd_line(), 0, "conf0");
    req(0, 1, 0, 32'h80, '0, 0, "rd80");
    req(1, 1, 1, 32'h80, rnd_line(), 0, "conf1");
    req(1, 1, 0, 32'h80, '0, 0, "rd80_l1");

    old = m0[3];
    @(negedge clk);
    drive(0, 0, 1, 32'hC0, rnd_line());
    seen = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (if0.mem_ready) seen = 1;
    end
    rst0 = 1'b1;
    drive(0, 0, 0, 32'h0, '0);
    repeat (3) begin
      @(negedge clk);
      chk_zero(0, "in_reset");
    end
    rst0 = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (if0.mem_ready) seen = 1;
    end
    chk("abort no ready", LB'(seen), LB'(0));
    chk("abort line kept", m0[3], old);
    req(0, 1, 0, 32'hC0, '0, 0, "rd_c0");

    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 40; i++) begin
        op = $urandom_range(0, 3);
        ra = $urandom_range(0, 32'h10FF);
        req(s, op != 1, op != 0, ra, rnd_line(),
            $urandom_range(0, 2), "rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
